pad_uart_frame_decoder: RTL and testbench



---
 rtl/pad_link_pkg.sv | 12 +
 rtl/vga_pkg.sv | 8 +
 rtl/pad_uart_frame_decoder_if.sv | 11 +
 rtl/pad_rx_timeout_counter.sv | 17 +
 rtl/pad_uart_frame_decoder.sv | 81 ++++++++
 tb/tb_pad_uart_frame_decoder.sv | 187 ++++++++++++++++++
 6 files changed

// File: rtl/pad_link_pkg.sv
// pad_link_pkg: pad-position link framing shared by the receive decoder and the future transmit encoder.
package pad_link_pkg;
  typedef enum logic [1:0] {IDLE, HI, LO, CHK} pad_rx_state_t;
  localparam logic [7:0] PAD_FRAME_HEADER   = vga_pkg::PAD_FRAME_HEADER;
  localparam int         PAD_Y_MAX          = vga_pkg::PAD_Y_MAX;
  localparam logic [9:0] PAD_Y_INIT         = 10'(vga_pkg::PAD_Y_INIT);
  localparam int         PAD_TIMEOUT_CYCLES = 65000;
  function automatic logic [7:0] pad_checksum(input logic [7:0] header, input logic [7:0] hi,
                                              input logic [7:0] lo);
    return header ^ hi ^ lo;
  endfunction
endpackage

// File: rtl/vga_pkg.sv
// vga_pkg: display geometry and the pad constants derived from it.
package vga_pkg;
  localparam int         VER_PIXELS       = 768;
  localparam int         PAD_HEIGHT       = 145;
  localparam int         PAD_Y_INIT       = 312;
  localparam logic [7:0] PAD_FRAME_HEADER = 8'hA5;
  localparam int         PAD_Y_MAX        = VER_PIXELS - PAD_HEIGHT;
endpackage

// File: rtl/pad_uart_frame_decoder_if.sv
// pad_uart_frame_decoder_if: UART byte stream in, validated pad position and frame status out.
interface pad_uart_frame_decoder_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [9:0] y_pad_uart;
  logic       frame_ok;
  logic       frame_err;
  logic [7:0] err_cnt;
  modport master(output rx_data, rx_valid, input y_pad_uart, frame_ok, frame_err, err_cnt);
  modport slave(input rx_data, rx_valid, output y_pad_uart, frame_ok, frame_err, err_cnt);
endinterface

// File: rtl/pad_rx_timeout_counter.sv
// pad_rx_timeout_counter: counts clk cycles since the last clear and flags when TIMEOUT_CYCLES is reached.
module pad_rx_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 65000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clear ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign expired = cnt_q == W'(TIMEOUT_CYCLES);
endmodule

// File: rtl/pad_uart_frame_decoder.sv
// pad_uart_frame_decoder: parses header/hi/lo/xor UART frames into a validated 10-bit pad position.
// Define PAD_RX_TIMEOUT_EN to abandon partial frames after an inter-byte timeout.
module pad_uart_frame_decoder
  import pad_link_pkg::*;
#(
  parameter logic [7:0] HEADER = PAD_FRAME_HEADER,
  parameter int         Y_MAX  = PAD_Y_MAX,
  parameter logic [9:0] Y_INIT = PAD_Y_INIT
`ifdef PAD_RX_TIMEOUT_EN
  ,
  parameter int         TIMEOUT_CYCLES = PAD_TIMEOUT_CYCLES
`endif
) (
  input logic                     clk,
  input logic                     rst_n,
  pad_uart_frame_decoder_if.slave bus
);
  pad_rx_state_t state_q, state_d;
  logic [7:0] hi_q, hi_d, lo_q, lo_d, err_cnt_q, err_cnt_d;
  logic [9:0] y_q, y_d, pos;
  logic ok_q, ok_d, err_q, err_d, hdr, hi_ok, sum_ok, timeout;
  assign pos    = {hi_q[1:0], lo_q};
  assign hdr    = bus.rx_data == HEADER;
  assign hi_ok  = bus.rx_data[7:2] == 6'd0;
  assign sum_ok = bus.rx_data == pad_checksum(HEADER, hi_q, lo_q);
`ifdef PAD_RX_TIMEOUT_EN
  logic expired;
  pad_rx_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (bus.rx_valid || state_q == IDLE || expired),
    .expired(expired)
  );
  // a byte arriving on the expiry cycle takes priority over the timeout
  assign timeout = expired && state_q != IDLE && !bus.rx_valid;
`else
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    if (bus.rx_valid)
      case (state_q)
        IDLE:    state_d = hdr ? HI : IDLE;
        HI:      state_d = hi_ok ? LO : hdr ? HI : IDLE;
        LO:      state_d = CHK;
        default: state_d = (!sum_ok && hdr) ? HI : IDLE;
      endcase
    else if (timeout) state_d = IDLE;
  end
  always_comb begin
    hi_d      = (bus.rx_valid && state_q == HI && hi_ok) ? bus.rx_data : hi_q;
    lo_d      = (bus.rx_valid && state_q == LO) ? bus.rx_data : lo_q;
    ok_d      = bus.rx_valid && state_q == CHK && sum_ok && pos <= 10'(Y_MAX);
    err_d     = bus.rx_valid ? ((state_q == HI && !hi_ok && !hdr) || (state_q == CHK && !ok_d)) : timeout;
    y_d       = ok_d ? pos : y_q;
    err_cnt_d = (err_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hi_q      <= '0;
      lo_q      <= '0;
      y_q       <= Y_INIT;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      y_q       <= y_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  assign bus.y_pad_uart = y_q;
  assign bus.frame_ok   = ok_q;
  assign bus.frame_err  = err_q;
  assign bus.err_cnt    = err_cnt_q;
endmodule

// File: tb/tb_pad_uart_frame_decoder.sv
// tb_pad_uart_frame_decoder: directed and randomized frames checked against a byte-level reference model.
module tb_pad_uart_frame_decoder;
  localparam int TIMEOUT = 65000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0, passes = 0, err_pulses = 0;
  bit both_seen = 0;
  int m_stage, m_y, m_errs;
  logic [7:0] m_hi, m_lo;
  logic m_ok, m_err;

  pad_uart_frame_decoder_if bus ();
  pad_uart_frame_decoder dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.frame_ok && bus.frame_err) both_seen = 1;
    if (bus.frame_err === 1'b1) err_pulses++;
  end

  task automatic model_reset;
    m_stage = 0; m_y = 312; m_errs = 0; m_ok = 0; m_err = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int p;
    logic [7:0] cs;
    m_ok = 0; m_err = 0;
    case (m_stage)
      0: if (b == 8'hA5) m_stage = 1;
      1: if (b < 8'd4) begin m_hi = b; m_stage = 2; end
         else if (b != 8'hA5) begin m_err = 1; m_stage = 0; end
      2: begin m_lo = b; m_stage = 3; end
      default: begin
        p = int'(m_hi) * 256 + int'(m_lo);
        cs = 8'hA5 ^ m_hi ^ m_lo;
        if (b == cs && p <= 623) begin m_y = p; m_ok = 1; m_stage = 0; end
        else begin m_err = 1; m_stage = (b != cs && b == 8'hA5) ? 1 : 0; end
      end
    endcase
    if (m_err && m_errs < 255) m_errs++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data = b;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1 bus.rx_valid = 1'b0;
    model_byte(b);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
    #23 rst_n = 1'b1;
    model_reset();
    #1;
    checks++; if (bus.y_pad_uart !== 10'd312) $display("FAIL reset_y: got %0d want 312", bus.y_pad_uart); else passes++;
    checks++; if (bus.err_cnt !== 8'd0) $display("FAIL reset_err_cnt: got %0d want 0", bus.err_cnt); else passes++;
    checks++; if (bus.frame_ok !== 1'b0 || bus.frame_err !== 1'b0) $display("FAIL reset_pulses: got ok=%b err=%b want 0 0", bus.frame_ok, bus.frame_err); else passes++;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h90); send_byte(8'h34);
    send_byte(8'hA5); send_byte(8'hFC);
    checks++; if (bus.y_pad_uart !== 10'd400 || bus.err_cnt !== 8'd1) $display("FAIL pre_reset: got y=%0d cnt=%0d want 400 1", bus.y_pad_uart, bus.err_cnt); else passes++;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.y_pad_uart !== 10'd312 || bus.err_cnt !== 8'd0) $display("FAIL async_reset: got y=%0d cnt=%0d want 312 0", bus.y_pad_uart, bus.err_cnt); else passes++;
    #4 rst_n = 1'b1;
    model_reset();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h90);
    idle(5);
    checks++; if (bus.y_pad_uart !== 10'd312) $display("FAIL partial_frame: got %0d want 312", bus.y_pad_uart); else passes++;
    #3 rst_n = 1'b0;
    #4 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_good;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h90); send_byte(8'h34);
    checks++; if (bus.frame_ok !== 1'b1 || bus.y_pad_uart !== 10'd400) $display("FAIL good_frame: got ok=%b y=%0d want 1 400", bus.frame_ok, bus.y_pad_uart); else passes++;
    idle(1);
    checks++; if (bus.frame_ok !== 1'b0) $display("FAIL good_ok_pulse: got %b want 0", bus.frame_ok); else passes++;
  endtask

  task automatic test_boundary;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h6F); send_byte(8'hC8);
    checks++; if (bus.frame_ok !== 1'b1 || bus.y_pad_uart !== 10'd623) $display("FAIL y_max: got ok=%b y=%0d want 1 623", bus.frame_ok, bus.y_pad_uart); else passes++;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'hBC); send_byte(8'h1B);
    checks++; if (bus.frame_err !== 1'b1 || bus.frame_ok !== 1'b0) $display("FAIL over_max_err: got err=%b ok=%b want 1 0", bus.frame_err, bus.frame_ok); else passes++;
    checks++; if (bus.y_pad_uart !== 10'd623 || bus.err_cnt !== 8'd1) $display("FAIL over_max_hold: got y=%0d cnt=%0d want 623 1", bus.y_pad_uart, bus.err_cnt); else passes++;
  endtask

  task automatic test_corrupt;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h90); send_byte(8'h35);
    checks++; if (bus.frame_err !== 1'b1 || bus.y_pad_uart !== 10'd623) $display("FAIL bad_sum: got err=%b y=%0d want 1 623", bus.frame_err, bus.y_pad_uart); else passes++;
    send_byte(8'hA5); send_byte(8'hA5);
    checks++; if (bus.frame_err !== 1'b0) $display("FAIL resync_no_err: got %b want 0", bus.frame_err); else passes++;
    send_byte(8'h01); send_byte(8'h90); send_byte(8'h34);
    checks++; if (bus.frame_ok !== 1'b1 || bus.y_pad_uart !== 10'd400) $display("FAIL resync_frame: got ok=%b y=%0d want 1 400", bus.frame_ok, bus.y_pad_uart); else passes++;
    send_byte(8'h11); send_byte(8'h22);
    idle(1);
    checks++; if (bus.err_cnt !== 8'(m_errs) || m_errs != 2) $display("FAIL garbage: got cnt=%0d want 2", bus.err_cnt); else passes++;
    send_byte(8'hA5); send_byte(8'hFC);
    checks++; if (bus.frame_err !== 1'b1 || bus.err_cnt !== 8'd3) $display("FAIL bad_hi: got err=%b cnt=%0d want 1 3", bus.frame_err, bus.err_cnt); else passes++;
  endtask

  task automatic test_timeout;
    int e0;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h6F); send_byte(8'hC8);
    send_byte(8'hA5); send_byte(8'h01);
    e0 = err_pulses;
    idle(TIMEOUT + 20);
`ifdef PAD_RX_TIMEOUT_EN
    m_stage = 0;
    if (m_errs < 255) m_errs++;
    checks++; if (err_pulses !== e0 + 1 || bus.err_cnt !== 8'(m_errs)) $display("FAIL timeout_err: got pulses=%0d cnt=%0d want %0d %0d", err_pulses - e0, bus.err_cnt, 1, m_errs); else passes++;
    send_byte(8'h90); send_byte(8'h34);
    checks++; if (bus.frame_ok !== 1'b0 || bus.y_pad_uart !== 10'd623) $display("FAIL timeout_drop: got ok=%b y=%0d want 0 623", bus.frame_ok, bus.y_pad_uart); else passes++;
`else
    checks++; if (err_pulses !== e0) $display("FAIL stall_no_err: got %0d pulses want 0", err_pulses - e0); else passes++;
    send_byte(8'h90); send_byte(8'h34);
    checks++; if (bus.frame_ok !== 1'b1 || bus.y_pad_uart !== 10'd400) $display("FAIL stall_complete: got ok=%b y=%0d want 1 400", bus.frame_ok, bus.y_pad_uart); else passes++;
`endif
  endtask

  task automatic test_random;
    logic [7:0] q[$];
    logic [7:0] hi, lo, cs, g;
    int kind, p, bad;
    bad = 0;
    for (int f = 0; f < 80; f++) begin
      kind = int'($urandom_range(0, 5));
      p = (kind == 1) ? int'($urandom_range(624, 1023)) : int'($urandom_range(0, 623));
      hi = 8'(p >> 8);
      lo = 8'(p);
      cs = 8'hA5 ^ hi ^ lo;
      g = 8'($urandom_range(0, 255));
      if (g == 8'hA5) g = 8'h5A;
      case (kind)
        0, 1: q = {8'hA5, hi, lo, cs};
        2: q = {8'hA5, hi, lo, cs ^ 8'(1 << $urandom_range(0, 7))};
        3: q = {g};
        4: q = {8'hA5, 8'($urandom_range(4, 255))};
        default: q = {8'hA5, 8'hA5, hi, lo, cs};
      endcase
      foreach (q[i]) begin
        send_byte(q[i]);
        if (bus.frame_ok !== m_ok || bus.frame_err !== m_err || bus.y_pad_uart !== 10'(m_y) || bus.err_cnt !== 8'(m_errs)) bad++;
      end
      idle(int'($urandom_range(0, 3)));
    end
    checks++; if (bad != 0) $display("FAIL random_stream: got %0d mismatching bytes want 0 (last y=%0d model %0d)", bad, bus.y_pad_uart, m_y); else passes++;
  endtask

  task automatic test_saturation;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h90); send_byte(8'h34);
    checks++; if (bus.y_pad_uart !== 10'd400) $display("FAIL sat_setup: got %0d want 400", bus.y_pad_uart); else passes++;
    for (int f = 0; f < 300; f++) begin
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h90); send_byte(8'h00);
    end
    checks++; if (bus.err_cnt !== 8'd255 || bus.frame_err !== 1'b1) $display("FAIL saturate: got cnt=%0d err=%b want 255 1", bus.err_cnt, bus.frame_err); else passes++;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h6F); send_byte(8'hC8);
    checks++; if (bus.y_pad_uart !== 10'd623 || bus.frame_ok !== 1'b1 || bus.err_cnt !== 8'd255) $display("FAIL post_sat_frame: got y=%0d ok=%b cnt=%0d want 623 1 255", bus.y_pad_uart, bus.frame_ok, bus.err_cnt); else passes++;
  endtask

  task automatic test_exclusive;
    checks++; if (both_seen !== 1'b0) $display("FAIL ok_err_exclusive: got both asserted want never"); else passes++;
  endtask

  initial begin
    test_reset();
    test_good();
    test_boundary();
    test_corrupt();
    test_timeout();
    test_random();
    test_saturation();
    test_exclusive();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
